// File: rtl/inertial_pkg.sv
// rtl/inertial_pkg.sv - shared states, config words and read addresses for the inertial sequencer
package inertial_pkg;

    typedef enum logic [2:0] {
        INIT_WAIT,
        CFG,
        WAIT_INT,
        RD,
        UPDATE
    } state_t;

    // INT enable, accel 208Hz, gyro 208Hz, rounding
    localparam logic [15:0] CFG_CMD [0:3] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};

    localparam logic [7:0] RD_PTCH_LO = 8'hA2;
    localparam logic [7:0] RD_PTCH_HI = 8'hA3;
    localparam logic [7:0] RD_AZ_LO   = 8'hAC;
    localparam logic [7:0] RD_AZ_HI   = 8'hAD;

    function automatic logic [15:0] rd_cmd(input logic [1:0] step);
        logic [7:0] addr;
        case (step)
            2'd0:    addr = RD_PTCH_LO;
            2'd1:    addr = RD_PTCH_HI;
            2'd2:    addr = RD_AZ_LO;
            default: addr = RD_AZ_HI;
        endcase
        return {addr, 8'h00};
    endfunction

endpackage

// File: rtl/inertial_seq.sv
// rtl/inertial_seq.sv - SPI command sequencer: power-up wait, sensor config, INT-driven 4-byte reads
module inertial_seq
    import inertial_pkg::*;
#(
    parameter int INIT_CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [15:0] cmd,
    output logic        wrt,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ,
    output logic        vld
);

    state_t                  state_q;
    logic [INIT_CNT_W-1:0]   cnt_q;
    logic                    int_s1_q;
    logic                    int_s2_q;
    logic [1:0]              step_q;
    logic                    guard_q;
    logic [7:0]              stg_ptch_lo_q;
    logic [7:0]              stg_ptch_hi_q;
    logic [7:0]              stg_az_lo_q;
    logic [15:0]             cmd_q;
    logic [15:0]             ptch_q;
    logic [15:0]             az_q;
    logic                    wrt_q;
    logic                    vld_q;

    logic [1:0]              step_nx;
    logic                    done_seen;

    assign step_nx   = step_q + 2'd1;
    // The master's done is stale during the wrt cycle and the one after it.
    assign done_seen = done && !wrt_q && !guard_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= INIT_WAIT;
            cnt_q         <= '0;
            int_s1_q      <= 1'b0;
            int_s2_q      <= 1'b0;
            step_q        <= 2'd0;
            guard_q       <= 1'b0;
            stg_ptch_lo_q <= 8'h00;
            stg_ptch_hi_q <= 8'h00;
            stg_az_lo_q   <= 8'h00;
            cmd_q         <= 16'h0000;
            ptch_q        <= 16'h0000;
            az_q          <= 16'h0000;
            wrt_q         <= 1'b0;
            vld_q         <= 1'b0;
        end else begin
            int_s1_q <= INT;
            int_s2_q <= int_s1_q;
            wrt_q    <= 1'b0;
            vld_q    <= 1'b0;
            guard_q  <= wrt_q;
            case (state_q)
                INIT_WAIT: begin
                    if (&cnt_q) begin
                        state_q <= CFG;
                        step_q  <= 2'd0;
                        cmd_q   <= CFG_CMD[0];
                        wrt_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CFG: begin
                    if (done_seen) begin
                        if (step_q == 2'd3) begin
                            state_q <= WAIT_INT;
                        end else begin
                            step_q <= step_nx;
                            cmd_q  <= CFG_CMD[step_nx];
                            wrt_q  <= 1'b1;
                        end
                    end
                end
                WAIT_INT: begin
                    if (int_s2_q) begin
                        state_q <= RD;
                        step_q  <= 2'd0;
                        cmd_q   <= rd_cmd(2'd0);
                        wrt_q   <= 1'b1;
                    end
                end
                RD: begin
                    if (done_seen) begin
                        case (step_q)
                            2'd0:    stg_ptch_lo_q <= rd_data[7:0];
                            2'd1:    stg_ptch_hi_q <= rd_data[7:0];
                            2'd2:    stg_az_lo_q   <= rd_data[7:0];
                            default: ;
                        endcase
                        if (step_q == 2'd3) begin
                            // Last byte goes straight to the outputs so both words update on one edge.
                            state_q <= UPDATE;
                            ptch_q  <= {stg_ptch_hi_q, stg_ptch_lo_q};
                            az_q    <= {rd_data[7:0], stg_az_lo_q};
                            vld_q   <= 1'b1;
                        end else begin
                            step_q <= step_nx;
                            cmd_q  <= rd_cmd(step_nx);
                            wrt_q  <= 1'b1;
                        end
                    end
                end
                UPDATE: begin
                    state_q <= WAIT_INT;
                end
                default: begin
                    state_q <= INIT_WAIT;
                end
            endcase
        end
    end

    assign cmd     = cmd_q;
    assign wrt     = wrt_q;
    assign ptch_rt = ptch_q;
    assign AZ      = az_q;
    assign vld     = vld_q;

endmodule

// File: tb/tb_inertial_seq.sv
// tb/tb_inertial_seq.sv - directed bench for inertial_seq with a behavioural SPI master model
module tb_inertial_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        INT = 1'b0;
    logic        done = 1'b1;
    logic [15:0] rd_data = 16'h0000;
    logic [15:0] cmd;
    logic        wrt;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;
    logic        vld;

    inertial_seq #(.INIT_CNT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (INT),
        .done    (done),
        .rd_data (rd_data),
        .cmd     (cmd),
        .wrt     (wrt),
        .ptch_rt (ptch_rt),
        .AZ      (AZ),
        .vld     (vld)
    );

    always #5 clk = ~clk;

    logic [15:0] cmd_log [$];
    logic [7:0]  script [$];
    int          busy_cnt = 0;
    int          vld_cnt = 0;
    int          viol = 0;
    logic        prev_wrt = 1'b0;

    // SPI master model: done drops on wrt and rises 40 clocks later with the next scripted byte.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
            done     = 1'b1;
        end else if (wrt) begin
            if (busy_cnt > 0) viol++;
            cmd_log.push_back(cmd);
            done     = 1'b0;
            busy_cnt = 40;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                done = 1'b1;
                if (cmd[15] && script.size() > 0) rd_data = {8'h5A, script.pop_front()};
                else rd_data = 16'h0000;
            end
        end
        if (wrt && prev_wrt) viol++;
        if (vld) vld_cnt++;
        prev_wrt = wrt;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_vld(input string tag);
        int i;
        i = 0;
        while (!vld && i < 2000) begin
            @(negedge clk);
            i++;
        end
        chk({tag, " vld seen"}, 32'(vld), 32'd1);
    endtask

    task automatic wait_log(input string tag, input int n);
        int i;
        i = 0;
        while (cmd_log.size() < n && i < 2000) begin
            @(negedge clk);
            i++;
        end
        chk({tag, " cmd count reached"}, 32'(cmd_log.size() >= n), 32'd1);
    endtask

    task automatic int_pulse(input string tag);
        int lat;
        INT = 1'b1;
        lat = 0;
        while (!wrt && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " INT to wrt latency<=3"}, 32'(wrt && lat <= 3), 32'd1);
        INT = 1'b0;
    endtask

    task automatic check_config(input string tag);
        int base;
        logic early;
        logic [15:0] exp_cfg [0:3];
        exp_cfg = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
        base  = cmd_log.size();
        early = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (wrt) early = 1'b1;
        end
        chk({tag, " no wrt during wait"}, 32'(early), 32'd0);
        @(negedge clk);
        chk({tag, " first wrt after wait"}, 32'(wrt), 32'd1);
        chk({tag, " first cmd"}, 32'(cmd), 32'h0D02);
        wait_log(tag, base + 4);
        repeat (60) @(negedge clk);
        chk({tag, " no extra wrt"}, 32'(cmd_log.size()), 32'(base + 4));
        for (int k = 0; k < 4; k++) chk({tag, " cfg cmd"}, 32'(cmd_log[base + k]), 32'(exp_cfg[k]));
    endtask

    logic [15:0] exp_rd [0:3];
    int          b;
    int          lat;
    logic        held;

    initial begin
        exp_rd = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

        // 1: reset state, power-up wait, configuration
        repeat (3) @(negedge clk);
        chk("reset cmd", 32'(cmd), 32'h0);
        chk("reset wrt", 32'(wrt), 32'h0);
        chk("reset ptch_rt", 32'(ptch_rt), 32'h0);
        chk("reset AZ", 32'(AZ), 32'h0);
        chk("reset vld", 32'(vld), 32'h0);
        rst_n = 1'b1;
        check_config("cfg1");

        // 2: single INT pulse
        script.push_back(8'h34); script.push_back(8'h12);
        script.push_back(8'hCD); script.push_back(8'hAB);
        b = cmd_log.size();
        int_pulse("rd1");
        wait_vld("rd1");
        chk("rd1 ptch_rt", 32'(ptch_rt), 32'h1234);
        chk("rd1 AZ", 32'(AZ), 32'hABCD);
        @(negedge clk);
        chk("rd1 vld one cycle", 32'(vld), 32'd0);
        for (int k = 0; k < 4; k++) chk("rd1 read cmd", 32'(cmd_log[b + k]), 32'(exp_rd[k]));
        repeat (50) @(negedge clk);
        chk("rd1 idle with INT low", 32'(cmd_log.size()), 32'(b + 4));

        // 3: INT held through the read, back-to-back sequences
        script.push_back(8'h01); script.push_back(8'h02);
        script.push_back(8'h03); script.push_back(8'h04);
        script.push_back(8'h05); script.push_back(8'h06);
        script.push_back(8'h07); script.push_back(8'h08);
        b = cmd_log.size();
        INT = 1'b1;
        wait_vld("rd2");
        chk("rd2 ptch_rt", 32'(ptch_rt), 32'h0201);
        chk("rd2 AZ", 32'(AZ), 32'h0403);
        lat = 0;
        while (!wrt && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("rd3 restart <=3 after vld", 32'(wrt && lat <= 3), 32'd1);
        INT = 1'b0;
        wait_vld("rd3");
        chk("rd3 ptch_rt", 32'(ptch_rt), 32'h0605);
        chk("rd3 AZ", 32'(AZ), 32'h0807);
        repeat (100) @(negedge clk);
        chk("rd3 stays WAIT_INT", 32'(cmd_log.size()), 32'(b + 8));
        for (int k = 0; k < 4; k++) chk("rd3 read cmd", 32'(cmd_log[b + 4 + k]), 32'(exp_rd[k]));

        // 4: reset during the second read of a sequence
        script.push_back(8'h11); script.push_back(8'h22);
        script.push_back(8'h33); script.push_back(8'h44);
        b = cmd_log.size();
        int_pulse("rd4");
        wait_log("rd4", b + 2);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid reset ptch_rt", 32'(ptch_rt), 32'h0);
        chk("mid reset AZ", 32'(AZ), 32'h0);
        chk("mid reset cmd", 32'(cmd), 32'h0);
        chk("mid reset wrt", 32'(wrt), 32'h0);
        script.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_config("cfg2");

        // 5: negative data, previous values held until vld
        script.push_back(8'h78); script.push_back(8'h56);
        script.push_back(8'h21); script.push_back(8'h43);
        int_pulse("rd5");
        wait_vld("rd5");
        chk("rd5 ptch_rt", 32'(ptch_rt), 32'h5678);
        chk("rd5 AZ", 32'(AZ), 32'h4321);
        repeat (5) @(negedge clk);
        script.push_back(8'h00); script.push_back(8'h80);
        script.push_back(8'hFF); script.push_back(8'hFF);
        int_pulse("rd6");
        held = 1'b1;
        for (int i = 0; i < 2000 && !vld; i++) begin
            if (ptch_rt !== 16'h5678 || AZ !== 16'h4321) held = 1'b0;
            @(negedge clk);
        end
        chk("rd6 outputs held before vld", 32'(held), 32'd1);
        chk("rd6 vld seen", 32'(vld), 32'd1);
        chk("rd6 ptch_rt", 32'(ptch_rt), 32'h8000);
        chk("rd6 AZ", 32'(AZ), 32'hFFFF);
        repeat (20) @(negedge clk);

        chk("vld strobe count", 32'(vld_cnt), 32'd5);
        chk("wrt protocol violations", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
